// File: rtl/input_conditioner_pkg.sv
// Shared helpers for the input conditioner.
// The only helper sizes the per-channel debounce counter.
package input_conditioner_pkg;

   // A debounce counter only has to reach depth-1, and it is never narrower than one bit.
   function automatic int counter_width(input int depth);
      int width;
      width = $clog2(depth);
      return (width < 1) ? 1 : width;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input bit: a synchroniser chain, a tick-qualified debounce counter,
// a registered stable level, and one-cycle rise/fall strobes.
module debounce_channel
   import input_conditioner_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   DEBOUNCE    = 4,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   input  logic tick,
   output logic level,
   output logic rise,
   output logic fall,
   output logic strobe_next
);

   localparam int CW = counter_width(DEBOUNCE);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   sync;
   logic [CW-1:0]          cnt;
   logic                   flip;

   assign sync        = sync_chain[SYNC_STAGES-1];
   assign flip        = (sync != level) && tick && (cnt == CNT_LAST);
   assign strobe_next = flip;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_chain <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], in};
      end
   end

   // Any cycle of agreement restarts qualification; ticks only advance a disagreement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         level <= RESET_LEVEL;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= flip & sync;
         fall <= flip & ~sync;
         if (sync == level) begin
            cnt <= '0;
         end else if (tick) begin
            if (flip) begin
               level <= sync;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: CHANNELS independent debounce channels plus a
// registered "changed" flag that pulses alongside any rise/fall strobe.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int                  CHANNELS    = 4,
   parameter int                  SYNC_STAGES = 2,
   parameter int                  DEBOUNCE    = 4,
   parameter logic [CHANNELS-1:0] RESET_LEVEL = {CHANNELS{1'b0}}
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] in,
   input  logic                tick,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                changed
);

   logic [CHANNELS-1:0] strobe_next;

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
      debounce_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEBOUNCE    (DEBOUNCE),
         .RESET_LEVEL (RESET_LEVEL[ch])
      ) u_channel (
         .clk         (clk),
         .reset       (reset),
         .in          (in[ch]),
         .tick        (tick),
         .level       (level[ch]),
         .rise        (rise[ch]),
         .fall        (fall[ch]),
         .strobe_next (strobe_next[ch])
      );
   end

   // Registered from the channels' next-strobe terms so it lands in the same cycle as rise/fall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         changed <= 1'b0;
      end else begin
         changed <= |strobe_next;
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios on the default
// configuration plus randomized traffic on three configurations against a reference model.
module tb_input_conditioner;

   localparam int NI = 3;

   logic       clk;
   logic       reset;
   logic [3:0] in;
   logic       tick;

   logic [3:0] d_level [NI];
   logic [3:0] d_rise  [NI];
   logic [3:0] d_fall  [NI];
   logic       d_chg   [NI];

   int checks = 0;
   int errors = 0;

   input_conditioner u_dut0 (
      .clk(clk), .reset(reset), .in(in), .tick(tick),
      .level(d_level[0]), .rise(d_rise[0]), .fall(d_fall[0]), .changed(d_chg[0])
   );

   input_conditioner #(.RESET_LEVEL(4'b0001)) u_dut1 (
      .clk(clk), .reset(reset), .in(in), .tick(tick),
      .level(d_level[1]), .rise(d_rise[1]), .fall(d_fall[1]), .changed(d_chg[1])
   );

   input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE(1)) u_dut2 (
      .clk(clk), .reset(reset), .in(in), .tick(tick),
      .level(d_level[2]), .rise(d_rise[2]), .fall(d_fall[2]), .changed(d_chg[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the input travels down a delay line of S samples, and a level
   // changes once the delayed input has disagreed with it for D qualified ticks in a row.
   int         m_s  [NI] = '{2, 2, 3};
   int         m_d  [NI] = '{4, 4, 1};
   logic [3:0] m_rl [NI] = '{4'b0000, 4'b0001, 4'b0000};
   logic [3:0] m_pipe [NI][8];
   int         m_run  [NI][4];
   logic [3:0] exp_level [NI];
   logic [3:0] exp_rise  [NI];
   logic [3:0] exp_fall  [NI];
   logic       exp_chg   [NI];
   logic [3:0] m_delayed;

   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < NI; i++) begin
         if (reset) begin
            for (int s = 0; s < 8; s++) m_pipe[i][s] = m_rl[i];
            for (int c = 0; c < 4; c++) m_run[i][c] = 0;
            exp_level[i] = m_rl[i];
            exp_rise[i]  = 4'b0000;
            exp_fall[i]  = 4'b0000;
            exp_chg[i]   = 1'b0;
         end else begin
            m_delayed   = m_pipe[i][m_s[i]-1];
            exp_rise[i] = 4'b0000;
            exp_fall[i] = 4'b0000;
            for (int c = 0; c < 4; c++) begin
               if (m_delayed[c] == exp_level[i][c]) begin
                  m_run[i][c] = 0;
               end else if (tick) begin
                  m_run[i][c] = m_run[i][c] + 1;
                  if (m_run[i][c] >= m_d[i]) begin
                     m_run[i][c]     = 0;
                     exp_level[i][c] = m_delayed[c];
                     if (m_delayed[c]) exp_rise[i][c] = 1'b1;
                     else              exp_fall[i][c] = 1'b1;
                  end
               end
            end
            exp_chg[i] = |(exp_rise[i] | exp_fall[i]);
            for (int s = 7; s > 0; s--) m_pipe[i][s] = m_pipe[i][s-1];
            m_pipe[i][0] = in;
         end
      end
   end

   task automatic settle();
      in   = 4'b0000;
      tick = 1'b1;
      repeat (14) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in    = 4'b0000;
      tick  = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (d_level[0] !== 4'b0000 || d_rise[0] !== 4'b0000 || d_fall[0] !== 4'b0000 || d_chg[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_dut0: got level=%b rise=%b fall=%b changed=%b, expected all zero",
                  d_level[0], d_rise[0], d_fall[0], d_chg[0]);
      end
      checks++;
      if (d_level[1] !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL reset_level_dut1: got %b, expected 0001", d_level[1]);
      end
      reset = 1'b0;
      settle();
   endtask

   task automatic test_clean_rise();
      settle();
      for (int k = 0; k < 10; k++) begin
         in = 4'b0001;
         @(negedge clk);
         checks++;
         if (d_level[0][0] !== 1'(k >= 5)) begin
            errors++;
            $display("[TB] FAIL clean_rise level edge=%0d: got %b, expected %b", k, d_level[0][0], k >= 5);
         end
         checks++;
         if (d_rise[0] !== ((k == 5) ? 4'b0001 : 4'b0000)) begin
            errors++;
            $display("[TB] FAIL clean_rise rise edge=%0d: got %b", k, d_rise[0]);
         end
         checks++;
         if (d_chg[0] !== 1'(k == 5) || d_fall[0] !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL clean_rise changed/fall edge=%0d: got changed=%b fall=%b", k, d_chg[0], d_fall[0]);
         end
      end
   endtask

   task automatic test_glitch();
      settle();
      for (int k = 0; k < 14; k++) begin
         in = (k < 3) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         checks++;
         if (d_level[0][1] !== 1'b0 || d_rise[0][1] !== 1'b0 || d_chg[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_short edge=%0d: got level=%b rise=%b changed=%b, expected 0",
                     k, d_level[0][1], d_rise[0][1], d_chg[0]);
         end
      end
      settle();
      for (int k = 0; k < 14; k++) begin
         in = (k < 4) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         checks++;
         if (d_level[0][1] !== 1'(k >= 5 && k < 9)) begin
            errors++;
            $display("[TB] FAIL glitch_long level edge=%0d: got %b", k, d_level[0][1]);
         end
         checks++;
         if (d_rise[0][1] !== 1'(k == 5) || d_fall[0][1] !== 1'(k == 9)) begin
            errors++;
            $display("[TB] FAIL glitch_long strobes edge=%0d: got rise=%b fall=%b", k, d_rise[0][1], d_fall[0][1]);
         end
      end
   endtask

   task automatic test_tick_gating();
      settle();
      for (int k = 0; k < 45; k++) begin
         in   = 4'b0100;
         tick = (k % 10 == 9);
         @(negedge clk);
         checks++;
         if (d_level[0][2] !== 1'(k >= 39) || d_rise[0][2] !== 1'(k == 39)) begin
            errors++;
            $display("[TB] FAIL tick_gating edge=%0d: got level=%b rise=%b", k, d_level[0][2], d_rise[0][2]);
         end
      end
      tick = 1'b0;
      in   = 4'b0000;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         checks++;
         if (d_level[0][2] !== 1'b1 || d_fall[0][2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tick_frozen edge=%0d: got level=%b fall=%b, expected 1/0", k, d_level[0][2], d_fall[0][2]);
         end
      end
      settle();
   endtask

   task automatic test_simultaneous();
      int pulses;
      pulses = 0;
      settle();
      for (int k = 0; k < 12; k++) begin
         in = 4'b1111;
         @(negedge clk);
         if (d_chg[0] === 1'b1) pulses++;
         checks++;
         if (d_rise[0] !== ((k == 5) ? 4'b1111 : 4'b0000) || d_chg[0] !== 1'(k == 5)) begin
            errors++;
            $display("[TB] FAIL simultaneous edge=%0d: got rise=%b changed=%b", k, d_rise[0], d_chg[0]);
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("[TB] FAIL simultaneous_pulses: got %0d, expected 1", pulses);
      end
      for (int k = 0; k < 12; k++) begin
         in = (k == 0) ? 4'b0111 : 4'b1111;
         @(negedge clk);
         checks++;
         if (d_level[0] !== 4'b1111 || d_chg[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL chatter edge=%0d: got level=%b changed=%b, expected 1111/0", k, d_level[0], d_chg[0]);
         end
      end
      settle();
   endtask

   task automatic test_async_reset();
      settle();
      in = 4'b0010;
      repeat (10) @(negedge clk);
      checks++;
      if (d_level[0] !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL async_pre level: got %b, expected 0010", d_level[0]);
      end
      in = 4'b0011;
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (d_level[0] !== 4'b0000 || d_rise[0] !== 4'b0000 || d_fall[0] !== 4'b0000 || d_chg[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got level=%b rise=%b fall=%b changed=%b, expected all zero",
                  d_level[0], d_rise[0], d_fall[0], d_chg[0]);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (d_level[0] !== ((k >= 5) ? 4'b0011 : 4'b0000) || d_rise[0] !== ((k == 5) ? 4'b0011 : 4'b0000)) begin
            errors++;
            $display("[TB] FAIL async_release edge=%0d: got level=%b rise=%b", k, d_level[0], d_rise[0]);
         end
      end
      settle();
   endtask

   task automatic test_reset_level();
      reset = 1'b1;
      in    = 4'b0001;
      tick  = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (d_level[1] !== 4'b0001 || d_rise[1] !== 4'b0000 || d_fall[1] !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_level_idle edge=%0d: got level=%b rise=%b fall=%b", k, d_level[1], d_rise[1], d_fall[1]);
         end
      end
      for (int k = 0; k < 10; k++) begin
         in = 4'b0000;
         @(negedge clk);
         checks++;
         if (d_level[1][0] !== 1'(k < 5) || d_fall[1] !== ((k == 5) ? 4'b0001 : 4'b0000)) begin
            errors++;
            $display("[TB] FAIL reset_level_fall edge=%0d: got level=%b fall=%b", k, d_level[1][0], d_fall[1]);
         end
      end
      settle();
   endtask

   task automatic test_random();
      logic [3:0] cur;
      cur = 4'b0000;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
         end
         in   = cur;
         tick = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (d_level[i] !== exp_level[i] || d_rise[i] !== exp_rise[i] ||
                d_fall[i] !== exp_fall[i] || d_chg[i] !== exp_chg[i]) begin
               errors++;
               $display("[TB] FAIL random dut%0d cyc=%0d: got l=%b r=%b f=%b c=%b, expected l=%b r=%b f=%b c=%b",
                        i, cyc, d_level[i], d_rise[i], d_fall[i], d_chg[i],
                        exp_level[i], exp_rise[i], exp_fall[i], exp_chg[i]);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      in    = 4'b0000;
      tick  = 1'b1;
      test_reset();
      test_clean_rise();
      test_glitch();
      test_tick_gating();
      test_simultaneous();
      test_async_reset();
      test_reset_level();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
